// File: rtl/cache_pkg.sv
// Shared opcode, response and enable encodings for the fully associative cache,
// plus a LOG2 helper used to size the replacement pointer.
package cache_pkg;

  localparam int unsigned OPCODE_WIDTH = 2;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    FLASH   = 2'b00,
    READ    = 2'b01,
    WRITE   = 2'b10,
    INVALID = 2'b11
  } opcode_t;

  localparam logic HIT           = 1'b1;
  localparam logic MISS          = 1'b0;
  localparam logic CACHE_ENABLE  = 1'b0;
  localparam logic CACHE_DISABLE = 1'b1;

  // Ceiling log2; n is a power of two >= 2 for every caller.
  function automatic int unsigned LOG2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_entry.sv
// One cache line: valid bit, tag and data storage with a combinational tag match.
module cache_entry #(
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_we,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_match,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_valid;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
    end
  end

  // Tag/data are qualified by r_valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag  <= i_tag;
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_match = r_valid && (r_tag == i_tag);
  assign o_data  = r_data;

endmodule

// File: rtl/cache.sv
// Fully associative cache: lowest-index match wins, misses fill the lowest free
// entry, and a round-robin pointer picks the victim once every entry is valid.
module cache
  import cache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ENTRIES_WIDTH = 64,
  localparam int unsigned LINE_WIDTH   = TAG_WIDTH + DATA_WIDTH + OPCODE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LINE_WIDTH-1:0] vector_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  hit_miss_out
);

  localparam int unsigned PTR_W = LOG2(ENTRIES_WIDTH);

  opcode_t                  w_op;
  logic [TAG_WIDTH-1:0]     w_tag;
  logic [DATA_WIDTH-1:0]    w_data;
  logic                     w_active;
  logic                     w_flash;
  logic [ENTRIES_WIDTH-1:0] w_match;
  logic [ENTRIES_WIDTH-1:0] w_valid;
  logic [ENTRIES_WIDTH-1:0] w_we;
  logic [DATA_WIDTH-1:0]    w_entry_data [ENTRIES_WIDTH];
  logic                     w_hit;
  logic                     w_free;
  logic [PTR_W-1:0]         w_hit_idx;
  logic [PTR_W-1:0]         w_free_idx;
  logic [PTR_W-1:0]         w_wr_idx;
  logic [PTR_W-1:0]         r_ptr;
  logic [DATA_WIDTH-1:0]    r_data_out;
  logic                     r_hit_miss;

  assign w_op     = opcode_t'(vector_in[LINE_WIDTH-1 -: OPCODE_WIDTH]);
  assign w_tag    = vector_in[DATA_WIDTH +: TAG_WIDTH];
  assign w_data   = vector_in[DATA_WIDTH-1:0];
  assign w_active = !reset && (enable != CACHE_DISABLE);
  assign w_flash  = w_active && (w_op == FLASH);

  for (genvar g = 0; g < ENTRIES_WIDTH; g++) begin : g_entry
    cache_entry #(
      .TAG_WIDTH (TAG_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_entry (
      .clk    (clk),
      .reset  (reset),
      .i_clear(w_flash),
      .i_we   (w_we[g]),
      .i_tag  (w_tag),
      .i_data (w_data),
      .o_valid(w_valid[g]),
      .o_match(w_match[g]),
      .o_data (w_entry_data[g])
    );
  end

  // Priority encoders: first match and first free slot, lowest index first.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < ENTRIES_WIDTH; i++) begin
      if (w_match[i] && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
      if (!w_valid[i] && !w_free) begin
        w_free     = 1'b1;
        w_free_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    w_wr_idx = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_ptr);
    w_we     = '0;
    if (w_active && (w_op == WRITE)) begin
      w_we[w_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= '0;
      r_hit_miss <= MISS;
      r_ptr      <= '0;
    end else if (enable == CACHE_ENABLE) begin
      case (w_op)
        READ: begin
          r_hit_miss <= w_hit ? HIT : MISS;
          r_data_out <= w_hit ? w_entry_data[w_hit_idx] : '0;
        end
        WRITE: begin
          r_hit_miss <= w_hit ? HIT : MISS;
          r_data_out <= w_data;
          if (!w_hit && !w_free) begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        FLASH: begin
          r_hit_miss <= MISS;
          r_data_out <= '0;
          r_ptr      <= '0;
        end
        default: begin
          r_hit_miss <= MISS;
          r_data_out <= '0;
        end
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign hit_miss_out = r_hit_miss;

endmodule

// File: tb/tb_cache.sv
// Directed bench for cache: a behavioural reference model pushes expected
// responses to a scoreboard queue, popped and checked one cycle later.
module tb_cache;
  import cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [25:0] vector_in;
  logic [15:0] data_out;
  logic        hit_miss_out;

  typedef struct packed {
    logic        hit;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  logic [15:0] m_data  [64];
  int unsigned m_ptr;
  exp_t        m_last;

  cache #(
    .TAG_WIDTH    (8),
    .DATA_WIDTH   (16),
    .ENTRIES_WIDTH(64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .vector_in   (vector_in),
    .data_out    (data_out),
    .hit_miss_out(hit_miss_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_fails=%0d", n_fails);
    $fatal(1, "watchdog expired");
  end

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_ptr  = 0;
    m_last = '0;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [7:0] t,
                             input logic [15:0] d, input bit dis, output exp_t e);
    int hit_i;
    int free_i;
    hit_i  = -1;
    free_i = -1;
    if (dis) begin
      e = m_last;
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (hit_i < 0 && m_valid[i] && m_tag[i] == t) hit_i = i;
        if (free_i < 0 && !m_valid[i]) free_i = i;
      end
      case (op)
        2'b01: e = (hit_i >= 0) ? {1'b1, m_data[hit_i]} : {1'b0, 16'h0000};
        2'b10: begin
          if (hit_i >= 0) begin
            m_data[hit_i] = d;
            e = {1'b1, d};
          end else if (free_i >= 0) begin
            m_valid[free_i] = 1'b1;
            m_tag[free_i]   = t;
            m_data[free_i]  = d;
            e = {1'b0, d};
          end else begin
            m_tag[m_ptr]  = t;
            m_data[m_ptr] = d;
            m_ptr = (m_ptr + 1) % 64;
            e = {1'b0, d};
          end
        end
        2'b00: begin
          for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
          m_ptr = 0;
          e = '0;
        end
        default: e = '0;
      endcase
      m_last = e;
    end
  endtask

  task automatic check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s scoreboard: got empty queue expected one entry", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      assert (hit_miss_out === e.hit) else begin
        n_fails++;
        $error("FAIL %s hit_miss_out: got %b expected %b", name, hit_miss_out, e.hit);
      end
      n_checks++;
      assert (data_out === e.data) else begin
        n_fails++;
        $error("FAIL %s data_out: got %h expected %h", name, data_out, e.data);
      end
    end
  endtask

  task automatic step(input string name, input logic [1:0] op, input logic [7:0] t,
                      input logic [15:0] d, input bit dis);
    exp_t e;
    reset     = 1'b0;
    enable    = dis;
    vector_in = {op, t, d};
    model_apply(op, t, d, dis, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  // Reset with enable high and a WRITE on the bus: reset must still win.
  task automatic do_reset(input string name);
    reset     = 1'b1;
    enable    = CACHE_DISABLE;
    vector_in = {WRITE, 8'h77, 16'h7777};
    model_reset();
    sb.push_back('0);
    @(posedge clk);
    #1;
    check(name);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = CACHE_DISABLE;
    vector_in = '0;
    @(posedge clk);
    #1;
    do_reset("reset_state");

    for (int i = 0; i < 64; i++) begin
      logic [7:0] t;
      t = 8'(i);
      step($sformatf("fill_wr_%02h", t), WRITE, t, (i == 0) ? 16'hFFFF : 16'(i - 1), 1'b0);
    end
    for (int i = 0; i < 64; i++) begin
      logic [7:0] t;
      t = 8'(i);
      step($sformatf("fill_rd_%02h", t), READ, t, 16'h0, 1'b0);
    end

    step("evict_wr_ff", WRITE, 8'hFF, 16'h1111, 1'b0);
    step("evict_rd_ff", READ, 8'hFF, 16'h0, 1'b0);
    step("evict_rd_00", READ, 8'h00, 16'h0, 1'b0);
    step("evict_rd_0f", READ, 8'h0F, 16'h0, 1'b0);
    step("evict2_wr_fe", WRITE, 8'hFE, 16'h2222, 1'b0);
    step("evict2_rd_01", READ, 8'h01, 16'h0, 1'b0);
    step("evict2_rd_fe", READ, 8'hFE, 16'h0, 1'b0);
    step("wrhit_wr_0f", WRITE, 8'h0F, 16'hBEEF, 1'b0);
    step("wrhit_rd_0f", READ, 8'h0F, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("rd_0a_%0d", i), READ, 8'h0A, 16'h0, 1'b0);

    step("flash", FLASH, 8'h31, 16'h0001, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] t;
      t = 8'(i);
      step($sformatf("postflash_rd_%02h", t), READ, t, 16'h0, 1'b0);
    end

    step("disabled_wr_05", WRITE, 8'h05, 16'hABCD, 1'b1);
    step("rd_05_after_disabled", READ, 8'h05, 16'h0, 1'b0);
    step("invalid_op", INVALID, 8'h0A, 16'h1234, 1'b0);

    // Refill after FLASH: the pointer restarts at 0, so entry 0 is the victim.
    for (int i = 0; i < 64; i++) begin
      logic [7:0] t;
      t = 8'(8'h40 + i);
      step($sformatf("refill_wr_%02h", t), WRITE, t, 16'(16'h4000 + i), 1'b0);
    end
    step("refill_evict_wr_80", WRITE, 8'h80, 16'h8080, 1'b0);
    step("refill_rd_40", READ, 8'h40, 16'h0, 1'b0);
    step("refill_rd_41", READ, 8'h41, 16'h0, 1'b0);
    step("refill_rd_80", READ, 8'h80, 16'h0, 1'b0);
    step("hold_hit_disabled", READ, 8'h99, 16'h0, 1'b1);

    do_reset("mid_reset");
    step("postreset_rd_41", READ, 8'h41, 16'h0, 1'b0);
    step("postreset_wr_22", WRITE, 8'h22, 16'h5A5A, 1'b0);
    step("postreset_rd_22", READ, 8'h22, 16'h0, 1'b0);
    step("postreset_hold", WRITE, 8'h33, 16'h3333, 1'b1);
    step("postreset_rd_33", READ, 8'h33, 16'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
